// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_port_arbiter_pkg;

    // Arbiter ownership state: free arbitration, or a burst lock held by one port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    // Requester indices used by the grant select and the read-return owner tag.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester's access port into the shared memory arbiter.
//
// Handshake: req acts as valid and gnt as ready. An access is issued in the
// cycle where req && gnt. The requester holds req, lock, we, addr and wdata
// stable until that cycle; the arbiter does not buffer anything. Read data
// comes back later as a one-cycle rvalid pulse with rdata alongside.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req;
    logic              lock;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter_rd_return_pipe.sv
// Tracks issued reads for the fixed memory latency and decodes which port
// the returning data belongs to.
module arb_rd_return_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic owner,
    output logic rvalid0,
    output logic rvalid1,
    output logic any_valid
);
    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] own;

    // Shift one {valid, owner} tag per cycle; the last stage lines up with mem_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            own <= '0;
        end else begin
            vld[0] <= issue;
            own[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                own[i] <= own[i-1];
            end
        end
    end

    assign rvalid0   = vld[RD_LAT-1] & (own[RD_LAT-1] == PORT_CPU);
    assign rvalid1   = vld[RD_LAT-1] & (own[RD_LAT-1] == PORT_LDR);
    assign any_valid = |vld;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the CPU datapath (port 0) and the loader/DMA
// (port 1): one access per cycle, round-robin on ties, optional burst lock
// that is broken after LOCK_MAX locked grants while the other port waits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   port0,
    mem_port_arbiter_if.slave   port1,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output arb_state_t          state_dbg
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_t       state, state_nxt;
    logic             rr, rr_nxt;          // 0 favours the CPU port on a tie
    logic [CNT_W-1:0] cnt, cnt_nxt;        // locked grants in the current burst
    logic [1:0]       req, lk;
    logic             own, oth;
    logic             pick, sel;
    logic             issue, rd_issue;
    logic             rv0, rv1, pipe_busy;

    assign req = {port1.req, port0.req};
    assign lk  = {port1.lock, port0.lock};

    // Ownership state, tie pointer and burst counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            rr    <= PORT_CPU;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grant selection and next ownership state.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        cnt_nxt   = cnt;
        pick      = 1'b0;
        sel       = PORT_CPU;
        own       = (state == ST_LOCK1) ? PORT_LDR : PORT_CPU;
        oth       = ~own;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (req[0] && req[1]) begin
                    pick   = 1'b1;
                    sel    = rr;
                    rr_nxt = ~rr;
                end else if (req[0]) begin
                    pick = 1'b1;
                    sel  = PORT_CPU;
                end else if (req[1]) begin
                    pick = 1'b1;
                    sel  = PORT_LDR;
                end
                if (pick && lk[sel]) begin
                    state_nxt = (sel == PORT_LDR) ? ST_LOCK1 : ST_LOCK0;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (req[oth] && cnt == CNT_MAX) begin
                    // Starvation bound reached: the waiting port gets this slot
                    // and the former owner is favoured on the next tie.
                    pick      = 1'b1;
                    sel       = oth;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    rr_nxt    = own;
                end else if (req[own]) begin
                    pick = 1'b1;
                    sel  = own;
                    if (lk[own]) begin
                        if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        rr_nxt    = oth;
                    end
                end else begin
                    pick      = req[oth];
                    sel       = oth;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Nothing is issued while reset is asserted, even if requests are pending.
    assign issue     = pick & rst;
    assign port0.gnt = issue & (sel == PORT_CPU);
    assign port1.gnt = issue & (sel == PORT_LDR);
    assign mem_en    = issue;
    assign mem_we    = issue & ((sel == PORT_LDR) ? port1.we : port0.we);
    assign mem_addr  = issue ? ((sel == PORT_LDR) ? port1.addr : port0.addr) : '0;
    assign mem_wdata = issue ? ((sel == PORT_LDR) ? port1.wdata : port0.wdata) : '0;
    assign rd_issue  = issue & ~mem_we;

    arb_rd_return_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue     (rd_issue),
        .owner     (sel),
        .rvalid0   (rv0),
        .rvalid1   (rv1),
        .any_valid (pipe_busy)
    );

    assign port0.rvalid = rv0;
    assign port1.rvalid = rv1;
    assign port0.rdata  = rv0 ? mem_rdata : '0;
    assign port1.rdata  = rv1 ? mem_rdata : '0;
    assign busy         = pipe_busy | (state != ST_IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration model and a read-return scoreboard.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int LOCK_MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic init_mem = 1'b1;
    logic [DW-1:0] seed_byte = '0;
    int errors = 0;
    int checks = 0;

    // clock / reset
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) q0 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) q1 ();

    logic en_a, we_a, busy_a, en_b, we_b, busy_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, rdata_a, wdata_b, rdata_b;
    arb_state_t st_a, st_b;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst), .port0(p0), .port1(p1),
        .mem_en(en_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_rdata(rdata_a), .busy(busy_a), .state_dbg(st_a)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .LOCK_MAX(LOCK_MAX)) dut3 (
        .clk(clk), .rst(rst), .port0(q0), .port1(q1),
        .mem_en(en_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_rdata(rdata_b), .busy(busy_b), .state_dbg(st_b)
    );

    function automatic logic [DW-1:0] init_val(int i);
        return DW'(i * 53 + 17) ^ seed_byte;
    endfunction

    // memories seen by the two arbiters (latency 1 and latency 3)
    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] mem_b [32];
    logic [DW-1:0] rd_a, rb1, rb2, rb3;
    logic [DW-1:0] ref_a [32];
    logic [DW-1:0] ref_b [32];

    always @(posedge clk) begin
        if (init_mem) for (int i = 0; i < 32; i++) mem_a[i] <= init_val(i);
        else if (en_a && we_a) mem_a[addr_a] <= wdata_a;
        rd_a <= (en_a && !we_a) ? mem_a[addr_a] : '0;
    end
    assign rdata_a = rd_a;

    always @(posedge clk) begin
        if (init_mem) for (int i = 0; i < 32; i++) mem_b[i] <= init_val(i);
        else if (en_b && we_b) mem_b[addr_b] <= wdata_b;
        rb1 <= (en_b && !we_b) ? mem_b[addr_b] : '0;
        rb2 <= rb1;
        rb3 <= rb2;
    end
    assign rdata_b = rb3;

    // scoreboard for randomized read returns
    logic [DW-1:0] exp_q[$];
    int due_q[$];
    int port_q[$];

    // driver tasks
    task automatic drive_idle();
        p0.req = 0; p0.lock = 0; p0.we = 0; p0.addr = '0; p0.wdata = '0;
        p1.req = 0; p1.lock = 0; p1.we = 0; p1.addr = '0; p1.wdata = '0;
        q0.req = 0; q0.lock = 0; q0.we = 0; q0.addr = '0; q0.wdata = '0;
        q1.req = 0; q1.lock = 0; q1.we = 0; q1.addr = '0; q1.wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 0;
        repeat (2) next_cycle();
        rst = 1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 0;
        p0.req = 1; p0.addr = 5'd3; p1.req = 1; p1.addr = 5'd7;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++; if ({p0.gnt, p1.gnt, p0.rvalid, p1.rvalid, en_a, we_a, busy_a} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {p0.gnt, p1.gnt, p0.rvalid, p1.rvalid, en_a, we_a, busy_a}); end
        checks++; if ({addr_a, wdata_a, p0.rdata, p1.rdata} !== 29'b0) begin errors++; $display("FAIL reset_bus: got %h expected 0", {addr_a, wdata_a, p0.rdata, p1.rdata}); end
        checks++; if (st_a !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", st_a, ST_IDLE); end
        next_cycle();
        rst = 1;
        @(negedge clk);
        checks++; if ({p0.gnt, p1.gnt} !== 2'b10) begin errors++; $display("FAIL reset_first_tie: got gnt0,gnt1=%b expected 10", {p0.gnt, p1.gnt}); end
        checks++; if (addr_a !== 5'd3) begin errors++; $display("FAIL reset_first_addr: got %0d expected 3", addr_a); end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++; if (p0.rvalid !== 1'b1 || p0.rdata !== ref_a[3]) begin errors++; $display("FAIL reset_first_read: got v=%b d=%h expected v=1 d=%h", p0.rvalid, p0.rdata, ref_a[3]); end
        next_cycle();
    endtask

    task automatic test_alternating_reads();
        logic e0;
        logic [DW-1:0] ed;
        do_reset();
        p0.req = 1; p0.addr = 5'd3; p1.req = 1; p1.addr = 5'd7;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) drive_idle();
            @(negedge clk);
            if (k < 4) begin
                e0 = ((k % 2) == 0);
                checks++; if (p0.gnt !== e0 || p1.gnt !== !e0) begin errors++; $display("FAIL alt_gnt[%0d]: got %b%b expected %b%b", k, p0.gnt, p1.gnt, e0, !e0); end
                checks++; if (addr_a !== (e0 ? 5'd3 : 5'd7) || en_a !== 1'b1) begin errors++; $display("FAIL alt_addr[%0d]: got en=%b a=%0d", k, en_a, addr_a); end
            end
            if (k > 0) begin
                e0 = (((k - 1) % 2) == 0);
                ed = e0 ? ref_a[3] : ref_a[7];
                checks++; if (p0.rvalid !== e0 || p1.rvalid !== !e0) begin errors++; $display("FAIL alt_rvalid[%0d]: got %b%b expected %b%b", k, p0.rvalid, p1.rvalid, e0, !e0); end
                checks++; if ((e0 ? p0.rdata : p1.rdata) !== ed) begin errors++; $display("FAIL alt_rdata[%0d]: got %h expected %h", k, e0 ? p0.rdata : p1.rdata, ed); end
            end
            next_cycle();
        end
    endtask

    task automatic test_burst_write();
        logic [DW-1:0] wd;
        arb_state_t es;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wd = DW'($urandom_range(0, 255));
            p1.req = 1; p1.we = 1; p1.lock = (k != 3); p1.addr = AW'(k); p1.wdata = wd;
            @(negedge clk);
            es = (k == 0) ? ST_IDLE : ST_LOCK1;
            checks++; if ({p1.gnt, p0.gnt, we_a} !== 3'b101) begin errors++; $display("FAIL burst_gnt[%0d]: got gnt1,gnt0,we=%b expected 101", k, {p1.gnt, p0.gnt, we_a}); end
            checks++; if (addr_a !== AW'(k) || wdata_a !== wd) begin errors++; $display("FAIL burst_bus[%0d]: got a=%0d d=%h expected a=%0d d=%h", k, addr_a, wdata_a, k, wd); end
            checks++; if (st_a !== es || busy_a !== (k != 0)) begin errors++; $display("FAIL burst_state[%0d]: got st=%0d busy=%b expected st=%0d", k, st_a, busy_a, es); end
            checks++; if (p0.rvalid !== 1'b0 || p1.rvalid !== 1'b0) begin errors++; $display("FAIL burst_rvalid[%0d]: got %b%b expected 00", k, p0.rvalid, p1.rvalid); end
            ref_a[k] = wd;
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        checks++; if (st_a !== ST_IDLE || busy_a !== 1'b0) begin errors++; $display("FAIL burst_end: got st=%0d busy=%b expected IDLE/0", st_a, busy_a); end
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            p0.req = (k < 4); p0.addr = AW'(k);
            @(negedge clk);
            if (k > 0) begin
                checks++; if (p0.rvalid !== 1'b1 || p0.rdata !== ref_a[k-1]) begin errors++; $display("FAIL burst_readback[%0d]: got v=%b d=%h expected v=1 d=%h", k - 1, p0.rvalid, p0.rdata, ref_a[k-1]); end
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_starvation();
        bit got0, new1, e0, e1;
        do_reset();
        got0 = 0; new1 = 1;
        p1.req = 1; p1.we = 1; p1.lock = 1;
        p0.we = 1; p0.addr = 5'd20; p0.wdata = DW'($urandom_range(0, 255));
        for (int c = 0; c < 10; c++) begin
            if (new1) begin p1.addr = AW'($urandom_range(0, 31)); p1.wdata = DW'($urandom_range(0, 255)); end
            p0.req = (c >= 2) && !got0;
            @(negedge clk);
            e0 = (c == 8); e1 = (c != 8);
            checks++; if (p0.gnt !== e0 || p1.gnt !== e1) begin errors++; $display("FAIL starve_gnt[%0d]: got %b%b expected %b%b", c, p0.gnt, p1.gnt, e0, e1); end
            if (c == 7) begin checks++; if (st_a !== ST_LOCK1) begin errors++; $display("FAIL starve_lock: got %0d expected %0d", st_a, ST_LOCK1); end end
            if (c == 9) begin checks++; if (st_a !== ST_IDLE) begin errors++; $display("FAIL starve_break: got %0d expected %0d", st_a, ST_IDLE); end end
            if (e0) begin ref_a[p0.addr] = p0.wdata; got0 = 1; end
            if (e1) ref_a[p1.addr] = p1.wdata;
            new1 = e1;
            next_cycle();
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        p0.req = 1; p0.we = 0; p0.addr = 5'd9;
        @(negedge clk);
        checks++; if (p0.gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt: got %b expected 1", p0.gnt); end
        rst = 0;
        #1;
        checks++; if (p0.gnt !== 1'b0 || en_a !== 1'b0) begin errors++; $display("FAIL midrst_gate: got gnt=%b en=%b expected 0 0", p0.gnt, en_a); end
        drive_idle();
        repeat (2) next_cycle();
        rst = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (p0.rvalid !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL midrst_ret[%0d]: got v=%b busy=%b expected 0 0", c, p0.rvalid, busy_a); end
            next_cycle();
        end
        // read already inside the latency-3 return pipe when reset hits
        q0.req = 1; q0.we = 0; q0.addr = 5'd2;
        @(negedge clk);
        next_cycle();
        drive_idle();
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL midrst_inflight: got busy=%b expected 1", busy_b); end
        rst = 0;
        #1;
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL midrst_clear: got busy=%b expected 0", busy_b); end
        repeat (2) next_cycle();
        rst = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (q0.rvalid !== 1'b0) begin errors++; $display("FAIL midrst_ret3[%0d]: got %b expected 0", c, q0.rvalid); end
            next_cycle();
        end
    endtask

    task automatic test_rd_lat3();
        bit e0, e1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            q0.req = 0; q1.req = 0;
            if (c == 0) begin q0.req = 1; q0.addr = 5'd4; end
            if (c == 1) begin q1.req = 1; q1.addr = 5'd11; end
            if (c == 2) begin q0.req = 1; q0.addr = 5'd20; end
            @(negedge clk);
            if (c < 3) begin
                checks++; if (q0.gnt !== (c != 1) || q1.gnt !== (c == 1)) begin errors++; $display("FAIL lat3_gnt[%0d]: got %b%b", c, q0.gnt, q1.gnt); end
            end
            e0 = (c == 3) || (c == 5); e1 = (c == 4);
            checks++; if (q0.rvalid !== e0 || q1.rvalid !== e1) begin errors++; $display("FAIL lat3_rvalid[%0d]: got %b%b expected %b%b", c, q0.rvalid, q1.rvalid, e0, e1); end
            if (c == 3) begin checks++; if (q0.rdata !== ref_b[4] || busy_b !== 1'b1) begin errors++; $display("FAIL lat3_d0: got %h busy=%b expected %h", q0.rdata, busy_b, ref_b[4]); end end
            if (c == 4) begin checks++; if (q1.rdata !== ref_b[11]) begin errors++; $display("FAIL lat3_d1: got %h expected %h", q1.rdata, ref_b[11]); end end
            if (c == 5) begin checks++; if (q0.rdata !== ref_b[20]) begin errors++; $display("FAIL lat3_d2: got %h expected %h", q0.rdata, ref_b[20]); end end
            if (c == 6) begin checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL lat3_idle: got busy=%b expected 0", busy_b); end end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_random();
        int owner, run, fav, g, o, pc;
        bit pend0, pend1;
        logic [1:0] rq, lk;
        logic e_we, e_busy, e_rv0, e_rv1;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd0, e_rd1, ed;
        do_reset();
        owner = -1; run = 0; fav = 0; pend0 = 0; pend1 = 0;
        exp_q.delete(); due_q.delete(); port_q.delete();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rq = {p1.req, p0.req}; lk = {p1.lock, p0.lock};
            // who should be served this cycle
            if (owner < 0) begin
                if (rq == 2'b11) g = fav; else if (rq[0]) g = 0; else if (rq[1]) g = 1; else g = -1;
            end else begin
                o = 1 - owner;
                if (rq[o] && run >= LOCK_MAX) g = o; else if (rq[owner]) g = owner; else if (rq[o]) g = o; else g = -1;
            end
            e_we = 0; e_addr = '0; e_wd = '0;
            if (g == 0) begin e_we = p0.we; e_addr = p0.addr; e_wd = p0.wdata; end
            if (g == 1) begin e_we = p1.we; e_addr = p1.addr; e_wd = p1.wdata; end
            checks++; if (p0.gnt !== (g == 0) || p1.gnt !== (g == 1) || en_a !== (g >= 0)) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b%b en=%b expected port %0d", c, p0.gnt, p1.gnt, en_a, g); end
            checks++; if (we_a !== e_we || addr_a !== e_addr || wdata_a !== e_wd) begin errors++; $display("FAIL rnd_bus[%0d]: got we=%b a=%0d d=%h expected we=%b a=%0d d=%h", c, we_a, addr_a, wdata_a, e_we, e_addr, e_wd); end
            e_busy = (owner >= 0) || (due_q.size() > 0);
            checks++; if (busy_a !== e_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, busy_a, e_busy); end
            e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
            if (due_q.size() > 0 && due_q[0] == c) begin
                void'(due_q.pop_front());
                pc = port_q.pop_front();
                ed = exp_q.pop_front();
                if (pc == 0) begin e_rv0 = 1; e_rd0 = ed; end else begin e_rv1 = 1; e_rd1 = ed; end
            end
            checks++; if (p0.rvalid !== e_rv0 || p1.rvalid !== e_rv1 || p0.rdata !== e_rd0 || p1.rdata !== e_rd1) begin errors++; $display("FAIL rnd_ret[%0d]: got %b%b %h %h expected %b%b %h %h", c, p0.rvalid, p1.rvalid, p0.rdata, p1.rdata, e_rv0, e_rv1, e_rd0, e_rd1); end
            if (g >= 0) begin
                if (e_we) ref_a[e_addr] = e_wd;
                else begin exp_q.push_back(ref_a[e_addr]); due_q.push_back(c + 1); port_q.push_back(g); end
            end
            // ownership bookkeeping for the next cycle
            if (owner < 0) begin
                if (rq == 2'b11) fav = 1 - fav;
                if (g >= 0 && lk[g]) begin owner = g; run = 1; end
            end else begin
                o = 1 - owner;
                if (g == owner && lk[owner]) begin if (run < LOCK_MAX) run++; end
                else if (g == owner) begin fav = o; owner = -1; run = 0; end
                else if (g == o && run >= LOCK_MAX) begin fav = owner; owner = -1; run = 0; end
                else begin owner = -1; run = 0; end
            end
            if (g == 0) pend0 = 0;
            if (g == 1) pend1 = 0;
            next_cycle();
            if (!pend0) begin
                p0.req = ($urandom_range(0, 7) != 0); p0.we = 1'($urandom_range(0, 1));
                p0.lock = ($urandom_range(0, 7) != 0);
                p0.addr = AW'($urandom_range(0, 31)); p0.wdata = DW'($urandom_range(0, 255));
                pend0 = p0.req;
            end
            if (!pend1) begin
                p1.req = ($urandom_range(0, 7) != 0); p1.we = 1'($urandom_range(0, 1));
                p1.lock = ($urandom_range(0, 7) != 0);
                p1.addr = AW'($urandom_range(0, 31)); p1.wdata = DW'($urandom_range(0, 255));
                pend1 = p1.req;
            end
        end
        drive_idle();
        next_cycle();
    endtask

    initial begin
        seed_byte = DW'($urandom_range(0, 255));
        for (int i = 0; i < 32; i++) begin
            ref_a[i] = init_val(i);
            ref_b[i] = init_val(i);
        end
        drive_idle();
        rst = 0;
        init_mem = 1;
        repeat (2) next_cycle();
        init_mem = 0;
        test_reset();
        test_alternating_reads();
        test_burst_write();
        test_starvation();
        test_reset_mid_read();
        test_rd_lat3();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
